// File: rtl/i2c_pkg.sv
// Shared types and widths for the single-address I2C slave core.
package i2c_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      WRITE     = 3'd3,
      WRITE_ACK = 3'd4,
      READ      = 3'd5,
      READ_ACK  = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

endpackage

// File: rtl/i2c_slave_core_if.sv
// User-side signals of the I2C slave core: own address, read data in, write data and done out.
interface i2c_slave_core_if;
   import i2c_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_rd;
   logic [DATA_W-1:0] data_wr;
   logic              done;

   modport slave  (input addr, input data_rd, output data_wr, output done);
   modport master (output addr, output data_rd, input data_wr, input done);

endinterface

// File: rtl/i2c_slave_core.sv
// Single-address, single-byte I2C slave clocked by SCL: samples/advances on falling SCL,
// updates its open-drain SDA drive on rising SCL.
module i2c_slave_core
   import i2c_pkg::*;
(
   input  logic           SCL,
   input  logic           rst,
   inout  wire            SDA,
   i2c_slave_core_if.slave bus
);

   state_t            state;
   logic [2:0]        bit_cnt;
   logic [DATA_W-2:0] rx_sr;
   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] data_wr_q;
   logic              done_q;
   logic              sda_oe;

   // Only seven bits are stored; the eighth comes straight from the pin on the last sample.
   assign rx_next = {rx_sr, SDA};

   always_ff @(negedge SCL or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         data_wr_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!SDA) begin
                  state   <= ADDR;
                  bit_cnt <= '0;
               end
            end
            ADDR: begin
               rx_sr   <= rx_next[DATA_W-2:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state <= (rx_next[DATA_W-1:1] == bus.addr) ? ADDR_ACK : WAIT_STOP;
            end
            ADDR_ACK: begin
               bit_cnt <= '0;
               if (rx_sr[0]) begin
                  state <= READ;
                  tx_sr <= bus.data_rd;
               end else begin
                  state <= WRITE;
               end
            end
            WRITE: begin
               rx_sr   <= rx_next[DATA_W-2:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  data_wr_q <= rx_next;
                  done_q    <= 1'b1;
                  state     <= WRITE_ACK;
               end
            end
            WRITE_ACK: state <= WAIT_STOP;
            READ: begin
               tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state <= READ_ACK;
            end
            READ_ACK: begin
               done_q <= 1'b1;
               if (!SDA) begin
                  tx_sr   <= bus.data_rd;
                  bit_cnt <= '0;
                  state   <= READ;
               end else begin
                  state <= WAIT_STOP;
               end
            end
            WAIT_STOP: begin
               if (SDA)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge SCL or posedge rst) begin
      if (rst) begin
         sda_oe <= 1'b0;
      end else begin
         case (state)
            ADDR_ACK, WRITE_ACK: sda_oe <= 1'b1;
            READ:                sda_oe <= ~tx_sr[DATA_W-1];
            default:             sda_oe <= 1'b0;
         endcase
      end
   end

   assign SDA         = sda_oe ? 1'b0 : 1'bz;
   assign bus.data_wr = data_wr_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a bit-level master plus a per-SCL-period expectation queue built from frame descriptions.
module tb_i2c_slave_core;
   import i2c_pkg::*;

   typedef struct {
      bit       m;
      bit       sl;
      bit [7:0] rd;
      bit       d;
      int       st;
      bit       tx;
      bit [7:0] dwr;
   } per_t;

   logic scl   = 1'b0;
   logic rst   = 1'b1;
   logic m_low = 1'b0;
   wire  sda;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_slave_core_if bus ();

   i2c_slave_core dut (
      .SCL (scl),
      .rst (rst),
      .SDA (sda),
      .bus (bus)
   );

   always #5 scl = ~scl;

   per_t     q[$];
   bit       busy      = 1'b0;
   bit [7:0] model_dwr = 8'h00;
   bit [6:0] own       = 7'h0F;
   bit [7:0] rbytes [4];
   int       n_checks  = 0;
   int       n_pass    = 0;
   int       done_cnt  = 0;
   int       tx_n      = 0;
   bit [7:0] rx_seen   = 8'h00;
   bit [7:0] last_tx   = 8'h00;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
   endtask

   task automatic push(input bit m, input bit sl, input bit [7:0] rd, input bit d, input int st, input bit tx);
      per_t p;
      p.m = m; p.sl = sl; p.rd = rd; p.d = d; p.st = st; p.tx = tx; p.dwr = model_dwr;
      q.push_back(p);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(1'b1, 1'b0, 8'($urandom), 1'b0, 0, 1'b0);
   endtask

   // Master writes one byte; slave ACKs address and data only on a match.
   task automatic wr_frame(input bit [6:0] a7, input bit [7:0] d);
      bit [7:0] ab;
      bit [7:0] rd;
      ab = {a7, 1'b0};
      rd = 8'($urandom);
      push(1'b0, 1'b0, rd, 1'b0, -1, 1'b0);
      for (int i = 7; i >= 0; i--) push(ab[i], 1'b0, rd, 1'b0, -1, 1'b0);
      if (a7 != own) begin
         push(1'b1, 1'b0, rd, 1'b0, 0, 1'b0);
         return;
      end
      push(1'b1, 1'b1, rd, 1'b0, -1, 1'b0);
      for (int i = 7; i >= 1; i--) push(d[i], 1'b0, rd, 1'b0, -1, 1'b0);
      model_dwr = d;
      push(d[0], 1'b0, rd, 1'b1, -1, 1'b0);
      push(1'b1, 1'b1, rd, 1'b0, -1, 1'b0);
      push(1'b1, 1'b0, rd, 1'b0, 0, 1'b0);
   endtask

   // Master reads n bytes from rbytes, ACKing all but the last; data_rd shows the next byte early.
   task automatic rd_frame(input bit [6:0] a7, input int n);
      bit [7:0] ab;
      bit [7:0] cur;
      bit [7:0] nxt;
      ab = {a7, 1'b1};
      push(1'b0, 1'b0, rbytes[0], 1'b0, -1, 1'b0);
      for (int i = 7; i >= 0; i--) push(ab[i], 1'b0, rbytes[0], 1'b0, -1, 1'b0);
      if (a7 != own) begin
         push(1'b1, 1'b0, rbytes[0], 1'b0, 0, 1'b0);
         return;
      end
      push(1'b1, 1'b1, rbytes[0], 1'b0, -1, 1'b0);
      for (int j = 0; j < n; j++) begin
         cur = rbytes[j];
         nxt = (j + 1 < n) ? rbytes[j+1] : 8'($urandom);
         for (int i = 7; i >= 0; i--) push(1'b1, ~cur[i], nxt, 1'b0, (i == 0) ? 6 : -1, 1'b1);
         push((j == n - 1), 1'b0, nxt, 1'b1, -1, 1'b0);
      end
      push(1'b1, 1'b0, 8'($urandom), 1'b0, 0, 1'b0);
   endtask

   task automatic wait_empty();
      int unsigned n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 4000) begin
         @(negedge scl);
         n++;
      end
      chk("drain", 32'(q.size()) + 32'(busy), 32'd0);
   endtask

   // Master driver and per-period compare against the queued expectations.
   initial begin
      per_t cur;
      bit   have;
      bus.data_rd = 8'h00;
      forever begin
         @(posedge scl);
         #1;
         have = (q.size() != 0);
         if (have) begin
            cur         = q.pop_front();
            busy        = 1'b1;
            m_low       = ~cur.m;
            bus.data_rd = cur.rd;
         end else begin
            m_low = 1'b0;
         end
         #2;
         if (have) begin
            chk("sda", 32'(sda), 32'(cur.m & ~cur.sl));
            if (cur.tx) begin
               rx_seen = {rx_seen[6:0], sda};
               tx_n++;
               if (tx_n % 8 == 0) last_tx = rx_seen;
            end
         end
         @(negedge scl);
         #2;
         if (have) begin
            chk("done", 32'(bus.done), 32'(cur.d));
            chk("data_wr", 32'(bus.data_wr), 32'(cur.dwr));
            if (cur.st >= 0) chk("state", 32'(dut.state), 32'(cur.st));
            if (bus.done) done_cnt++;
            busy = 1'b0;
         end
      end
   end

   initial begin
      int d0;
      bit [6:0] tgt;
      bus.addr = own;
      repeat (3) @(negedge scl);
      #2;
      chk("rst_sda", 32'(sda), 32'd1);
      chk("rst_data_wr", 32'(bus.data_wr), 32'h00);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_state", 32'(dut.state), 32'd0);
      rst = 1'b0;

      // Write 0xAB twice to 0x0F
      for (int k = 0; k < 2; k++) begin
         d0 = done_cnt;
         idle(2);
         wr_frame(7'h0F, 8'hAB);
         idle(2);
         wait_empty();
         chk("wr_data", 32'(bus.data_wr), 32'h0000_00AB);
         chk("wr_done_pulses", 32'(done_cnt - d0), 32'd1);
      end

      // Single-byte read with NACK
      d0 = done_cnt;
      rbytes[0] = 8'hAB;
      rd_frame(7'h0F, 1);
      idle(2);
      wait_empty();
      chk("rd_byte", 32'(last_tx), 32'h0000_00AB);
      chk("rd_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("rd_keeps_data_wr", 32'(bus.data_wr), 32'h0000_00AB);

      // Two-byte read: ACK then NACK
      d0 = done_cnt;
      rbytes[0] = 8'h5A;
      rbytes[1] = 8'hC3;
      rd_frame(7'h0F, 2);
      idle(2);
      wait_empty();
      chk("rd2_last_byte", 32'(last_tx), 32'h0000_00C3);
      chk("rd2_done_pulses", 32'(done_cnt - d0), 32'd2);

      // Address mismatch
      d0 = done_cnt;
      wr_frame(7'h10, 8'h55);
      idle(3);
      wait_empty();
      chk("mis_data_wr", 32'(bus.data_wr), 32'h0000_00AB);
      chk("mis_done_pulses", 32'(done_cnt - d0), 32'd0);

      // Randomized frames
      for (int k = 0; k < 16; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            own      = 7'($urandom);
            bus.addr = own;
         end
         tgt = ($urandom_range(0, 2) == 0) ? 7'($urandom) : own;
         if ($urandom_range(0, 1) == 0) begin
            wr_frame(tgt, 8'($urandom));
         end else begin
            for (int j = 0; j < 4; j++) rbytes[j] = 8'($urandom);
            rd_frame(tgt, $urandom_range(1, 3));
         end
         idle(2);
         wait_empty();
      end

      // Reset in the middle of a read data byte of all zeros
      own      = 7'h0F;
      bus.addr = own;
      idle(2);
      wait_empty();
      rbytes[0] = 8'h00;
      rd_frame(7'h0F, 1);
      while (q.size() > 13) void'(q.pop_back());
      wait_empty();
      @(posedge scl);
      #2;
      chk("mid_drive_low", 32'(sda), 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_sda", 32'(sda), 32'd1);
      chk("mid_rst_state", 32'(dut.state), 32'd0);
      chk("mid_rst_data_wr", 32'(bus.data_wr), 32'h00);
      model_dwr = 8'h00;
      #3;
      rst = 1'b0;
      idle(2);
      wr_frame(7'h0F, 8'h3C);
      idle(2);
      wait_empty();
      chk("post_rst_wr", 32'(bus.data_wr), 32'h0000_003C);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
